// File: rtl/game_timer_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
// Shared types and constants for the game timer scheduler.
//   chan_state_t   : per-channel state (IDLE / RUN)
//   DEF_NUM_CH     : default number of timer channels
//   DEF_CNT_W      : default width of duration / remaining counters (ticks)
//   TICKS_PER_SEC  : slowClk tick rate, for callers converting seconds to ticks
// -----------------------------------------------------------------------------
package timer_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int TICKS_PER_SEC = 30;

endpackage : timer_sched_pkg

// File: rtl/game_timer_scheduler_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One countdown channel: IDLE/RUN FSM, remaining counter, reload register and
// periodic flag. Priority within a cycle is cancel > arm > tick.
// Ports:
//   clk, resetN     : clock, asynchronous active-low reset
//   tick_eff        : qualified tick (slowClk & ~pause)
//   arm             : start/restart strobe; samples duration and periodic
//   periodic        : 1 = auto-reload on expiry, 0 = one-shot
//   duration        : duration in ticks (0 = immediate expiry)
//   cancel          : abort strobe, no expiry generated
//   active          : channel is in RUN
//   expired         : registered 1-clk expiry pulse
//   remaining       : registered remaining tick count
// -----------------------------------------------------------------------------
module timer_channel
    import timer_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick_eff,
    input  logic             arm,
    input  logic             periodic,
    input  logic [CNT_W-1:0] duration,
    input  logic             cancel,
    output logic             active,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] w_reload_nxt;
    logic             r_per_flag;
    logic             w_per_flag_nxt;
    logic             r_expired;
    logic             w_expired_nxt;

    // State, counter, reload and expiry registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_remaining <= CNT_ZERO;
            r_reload    <= CNT_ZERO;
            r_per_flag  <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_reload    <= w_reload_nxt;
            r_per_flag  <= w_per_flag_nxt;
            r_expired   <= w_expired_nxt;
        end
    end

    // Next-state logic: cancel beats arm, arm beats a tick in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_reload_nxt    = r_reload;
        w_per_flag_nxt  = r_per_flag;
        w_expired_nxt   = 1'b0;

        if (cancel) begin
            // Abort silently, even if this cycle's tick would have expired it.
            w_state_nxt     = IDLE;
            w_remaining_nxt = CNT_ZERO;
        end else if (arm) begin
            if (duration != CNT_ZERO) begin
                w_state_nxt     = RUN;
                w_remaining_nxt = duration;
                w_reload_nxt    = duration;
                w_per_flag_nxt  = periodic;
            end else begin
                // Zero duration expires immediately and never runs.
                w_state_nxt     = IDLE;
                w_remaining_nxt = CNT_ZERO;
                w_expired_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (tick_eff) begin
                        // <= 1 rather than == 1 so a zero count can never wrap.
                        if (r_remaining <= CNT_ONE) begin
                            w_expired_nxt = 1'b1;
                            if (r_per_flag) begin
                                w_state_nxt     = RUN;
                                w_remaining_nxt = r_reload;
                            end else begin
                                w_state_nxt     = IDLE;
                                w_remaining_nxt = CNT_ZERO;
                            end
                        end else begin
                            w_remaining_nxt = r_remaining - CNT_ONE;
                        end
                    end else begin
                        w_remaining_nxt = r_remaining;
                    end
                end
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = CNT_ZERO;
                end
            endcase
        end
    end

    assign active    = (r_state == RUN);
    assign expired   = r_expired;
    assign remaining = r_remaining;

endmodule : timer_channel

// File: rtl/game_timer_scheduler.sv
// -----------------------------------------------------------------------------
// game_timer_scheduler
// Multi-channel countdown scheduler clocked by the shared 30 Hz tick enable.
// Each channel is armed with a duration in ticks, counts down in parallel and
// pulses its expired bit for one clk on expiry. pause freezes all counting.
// Ports:
//   clk, resetN   : clock, asynchronous active-low reset
//   slowClk       : 1-clk tick enable
//   pause         : global freeze of tick counting (arm/cancel still act)
//   arm           : per-channel start/restart strobe
//   periodic      : per-channel auto-reload mode, sampled with arm
//   duration      : packed per-channel durations, channel i at [i*CNT_W +: CNT_W]
//   cancel        : per-channel abort strobe
//   rd_sel        : channel index for rd_remaining
//   active        : per-channel running flags
//   expired       : per-channel registered expiry pulses
//   rd_remaining  : remaining ticks of channel rd_sel (0 if out of range)
//   any_active    : OR of active
// -----------------------------------------------------------------------------
module game_timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    slowClk,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       arm,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] duration,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       expired,
    output logic [CNT_W-1:0]        rd_remaining,
    output logic                    any_active
);

    logic                w_tick_eff;
    logic [NUM_CH-1:0]   w_active;
    logic [NUM_CH-1:0]   w_expired;
    logic [CNT_W-1:0]    w_remaining [NUM_CH];
    logic [CNT_W-1:0]    w_rd_remaining;

    assign w_tick_eff = slowClk & ~pause;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .resetN    (resetN),
            .tick_eff  (w_tick_eff),
            .arm       (arm[g]),
            .periodic  (periodic[g]),
            .duration  (duration[g*CNT_W +: CNT_W]),
            .cancel    (cancel[g]),
            .active    (w_active[g]),
            .expired   (w_expired[g]),
            .remaining (w_remaining[g])
        );
    end

    // Status readback mux; out-of-range selects read as zero.
    always_comb begin
        w_rd_remaining = CNT_W'(0);
        if (32'(rd_sel) < NUM_CH) begin
            w_rd_remaining = w_remaining[rd_sel];
        end else begin
            w_rd_remaining = CNT_W'(0);
        end
    end

    assign active       = w_active;
    assign expired      = w_expired;
    assign rd_remaining = w_rd_remaining;
    assign any_active   = |w_active;

endmodule : game_timer_scheduler
